// File: rtl/shift_seq_pkg.sv
// Shared constants and types for the shift sequencer: shifter op codes,
// the FSM state enum and the default shift-amount width.
package shift_seq_pkg;

   localparam int AMT_W_DEF = 4;

   localparam logic [1:0] SH_PASS  = 2'b00;
   localparam logic [1:0] SH_LEFT  = 2'b01;
   localparam logic [1:0] SH_RIGHT = 2'b10;
   localparam logic [1:0] SH_ASR   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step 16-bit shifter: pass, left, logical right or arithmetic right
// by exactly one bit. Bits shifted out are dropped.
module shifter
   import shift_seq_pkg::*;
(
   input  logic [15:0] in,
   input  logic [1:0]  shift,
   output logic [15:0] sout
);

   always_comb begin
      sout = in;
      case (shift)
         SH_LEFT:  sout = {in[14:0], 1'b0};
         SH_RIGHT: sout = {1'b0, in[15:1]};
         SH_ASR:   sout = {in[15], in[15:1]};
         default:  sout = in;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller: one shifter step per cycle on an internal
// accumulator. Optional early exit on a fixed point: SHIFT_SEQ_EARLY_EXIT_EN.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int AMT_W = AMT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [15:0]      in_data,
   input  logic [1:0]       in_shift,
   input  logic [AMT_W-1:0] in_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic             busy
);

   state_t           r_state;
   state_t           w_next_state;
   logic [15:0]      r_acc;
   logic [1:0]       r_op;
   logic [AMT_W-1:0] r_count;
   logic [15:0]      w_step;
   logic             w_fixed;

   shifter u_shifter (
      .in    (r_acc),
      .shift (r_op),
      .sout  (w_step)
   );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
   // Further steps cannot change acc once it is a fixed point of the op.
   assign w_fixed = (w_step == r_acc);
`else
   assign w_fixed = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (start_valid) begin
               if (in_amt == '0 || in_shift == SH_PASS) w_next_state = DONE;
               else                                     w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (r_count <= AMT_W'(1) || w_fixed) w_next_state = DONE;
         end
         DONE: begin
            if (out_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_op    <= SH_PASS;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (start_valid) begin
                  r_acc   <= in_data;
                  r_op    <= in_shift;
                  r_count <= in_amt;
               end
            end
            SHIFT: begin
               r_acc <= w_step;
               if (r_count != '0) r_count <= r_count - AMT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // start_ready is gated by reset so nothing is handshaken during reset.
   assign start_ready = (r_state == IDLE) && !reset;
   assign out_valid   = (r_state == DONE);
   assign out_data    = r_acc;
   assign busy        = (r_state != IDLE);

endmodule
